// File: rtl/ysyx_22041412_mul_pkg.sv
// Shared definitions for the EXU-side multiplier controller.
// Contents:
//   - RV64M multiply op codes carried on req_op_i (5-7 are illegal)
//   - controller state encoding
//   - operand signedness codes for mul_signed_o ([1] multiplicand, [0] multiplier)
//   - decoded control bundle produced by ysyx_22041412_mul_dec
//   - helper that sign-extends a 32-bit word result to 64 bits
package ysyx_22041412_mul_pkg;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpMulw   = 3'd4;

  localparam logic [1:0] SgnSS = 2'b11;
  localparam logic [1:0] SgnSU = 2'b10;
  localparam logic [1:0] SgnUU = 2'b00;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StDone  = 2'd2,
    StAbort = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic       legal;
    logic       mulw;
    logic [1:0] sgn;
    logic       mode;
  } mul_ctrl_t;

  function automatic logic [63:0] sext_word(input logic [31:0] w);
    return {{32{w[31]}}, w};
  endfunction

endpackage

// File: rtl/ysyx_22041412_mul_dec.sv
// Combinational decoder from RV64M multiply op to multiplier controls.
// Ports:
//   op_i   : 3-bit op code (see package; 5-7 illegal)
//   ctrl_o : {legal, mulw, signed[1:0], mode}
// Illegal codes return an all-zero bundle, so legal=0 tells the controller
// to skip the multiplier entirely.
module ysyx_22041412_mul_dec
  import ysyx_22041412_mul_pkg::*;
(
  input  logic [2:0] op_i,
  output mul_ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (op_i)
      OpMul: begin
        ctrl_o.legal = 1'b1;
        ctrl_o.sgn   = SgnUU;
        ctrl_o.mode  = 1'b0;
      end
      OpMulh: begin
        ctrl_o.legal = 1'b1;
        ctrl_o.sgn   = SgnSS;
        ctrl_o.mode  = 1'b1;
      end
      OpMulhsu: begin
        ctrl_o.legal = 1'b1;
        ctrl_o.sgn   = SgnSU;
        ctrl_o.mode  = 1'b1;
      end
      OpMulhu: begin
        ctrl_o.legal = 1'b1;
        ctrl_o.sgn   = SgnUU;
        ctrl_o.mode  = 1'b1;
      end
      OpMulw: begin
        ctrl_o.legal = 1'b1;
        ctrl_o.mulw  = 1'b1;
        ctrl_o.sgn   = SgnUU;
        ctrl_o.mode  = 1'b0;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_mul_ctrl.sv
// EXU-side initiator for the iterative radix-4 Booth multiplier.
// Accepts one multiply op at a time, drives the multiplier's hold-valid
// request, captures its one-cycle result pulse and buffers the write-back.
// Ports:
//   clk, rst (async, active-low), flush (abandon current op)
//   req_*    : op request from EXU (valid/ready, op, src1, src2, rd)
//   busy_o   : stall, high whenever not idle
//   wb_*     : buffered result (valid/ready, data, rd)
//   err_o    : one-cycle pulse when the response watchdog fires
//   mul_*    : multiplier interface (request, operands, controls, flush,
//              ready, done pulse and result)
// All outputs are registered except req_ready_o and busy_o.
module ysyx_22041412_mul_ctrl
  import ysyx_22041412_mul_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned TIMEOUT = 40,
  parameter int unsigned CNT_W   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic [XLEN-1:0] req_src1_i,
  input  logic [XLEN-1:0] req_src2_i,
  input  logic [4:0]      req_rd_i,
  output logic            busy_o,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [XLEN-1:0] wb_data_o,
  output logic [4:0]      wb_rd_o,
  output logic            err_o,
  output logic            mul_req_o,
  output logic [XLEN-1:0] mul_multiplicand_o,
  output logic [XLEN-1:0] mul_multiplier_o,
  output logic            mulw_o,
  output logic [1:0]      mul_signed_o,
  output logic            mul_mode_o,
  output logic            mul_flush_o,
  output logic            mul_ready_o,
  input  logic            mul_done_i,
  input  logic [XLEN-1:0] mul_result_i
);

  mul_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;

  mul_ctrl_t       w_ctrl;
  logic            w_accept;
  logic            w_timeout;
  logic [XLEN-1:0] w_result;

  ysyx_22041412_mul_dec u_dec (
    .op_i   (req_op_i),
    .ctrl_o (w_ctrl)
  );

  assign req_ready_o = (r_state == StIdle) & ~flush;
  assign busy_o      = (r_state != StIdle);
  assign w_accept    = req_valid_i & req_ready_o;

  // r_cnt holds the number of REQ cycles already completed, so the abort
  // edge is the TIMEOUT-th edge spent in REQ.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Word ops: the multiplier's upper half is not trusted, rebuild it from bit 31.
  assign w_result = mulw_o ? {{(XLEN-32){mul_result_i[31]}}, mul_result_i[31:0]}
                           : mul_result_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state            <= StIdle;
      r_cnt              <= '0;
      wb_valid_o         <= 1'b0;
      wb_data_o          <= '0;
      wb_rd_o            <= '0;
      err_o              <= 1'b0;
      mul_req_o          <= 1'b0;
      mul_multiplicand_o <= '0;
      mul_multiplier_o   <= '0;
      mulw_o             <= 1'b0;
      mul_signed_o       <= '0;
      mul_mode_o         <= 1'b0;
      mul_flush_o        <= 1'b0;
      mul_ready_o        <= 1'b0;
    end else begin
      // Pulses default low and are raised only on the edge entering ABORT.
      mul_flush_o <= 1'b0;
      err_o       <= 1'b0;

      case (r_state)
        StIdle: begin
          if (w_accept) begin
            mul_multiplicand_o <= req_src1_i;
            mul_multiplier_o   <= req_src2_i;
            wb_rd_o            <= req_rd_i;
            mulw_o             <= w_ctrl.mulw;
            mul_signed_o       <= w_ctrl.sgn;
            mul_mode_o         <= w_ctrl.mode;
            if (w_ctrl.legal) begin
              r_state     <= StReq;
              r_cnt       <= '0;
              mul_req_o   <= 1'b1;
              mul_ready_o <= 1'b1;
            end else begin
              // Illegal op never touches the multiplier; write back zero.
              r_state    <= StDone;
              wb_valid_o <= 1'b1;
              wb_data_o  <= '0;
            end
          end
        end

        StReq: begin
          if (flush) begin
            // Flush beats a same-cycle done; the result is dropped.
            r_state     <= StAbort;
            mul_req_o   <= 1'b0;
            mul_ready_o <= 1'b0;
            mul_flush_o <= 1'b1;
          end else if (mul_done_i) begin
            // Dropping mul_req_o here stops the multiplier from restarting.
            r_state     <= StDone;
            mul_req_o   <= 1'b0;
            mul_ready_o <= 1'b0;
            wb_valid_o  <= 1'b1;
            wb_data_o   <= w_result;
          end else if (w_timeout) begin
            r_state     <= StAbort;
            mul_req_o   <= 1'b0;
            mul_ready_o <= 1'b0;
            mul_flush_o <= 1'b1;
            err_o       <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        StDone: begin
          if (flush || wb_ready_i) begin
            wb_valid_o <= 1'b0;
            r_state    <= StIdle;
          end
        end

        // Single cycle with valid low so the multiplier sees the drop;
        // any late done pulse here is ignored.
        StAbort: begin
          r_state <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_mul_ctrl.sv
module tb_ysyx_22041412_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_op_i = '0;
  logic [63:0] req_src1_i = '0;
  logic [63:0] req_src2_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        busy_o;
  logic        wb_valid_o;
  logic        wb_ready_i = 1'b0;
  logic [63:0] wb_data_o;
  logic [4:0]  wb_rd_o;
  logic        err_o;
  logic        mul_req_o;
  logic [63:0] mul_multiplicand_o;
  logic [63:0] mul_multiplier_o;
  logic        mulw_o;
  logic [1:0]  mul_signed_o;
  logic        mul_mode_o;
  logic        mul_flush_o;
  logic        mul_ready_o;
  logic        mul_done_i;
  logic [63:0] mul_result_i;

  // Stub multiplier, or manual drive when stub_en=0.
  logic        stub_en = 1'b1;
  int          stub_lat = 4;
  int          stub_cnt = 0;
  logic        stub_done = 1'b0;
  logic [63:0] stub_res = '0;
  logic        man_done = 1'b0;
  logic [63:0] man_res = '0;

  assign mul_done_i   = stub_en ? stub_done : man_done;
  assign mul_result_i = stub_en ? stub_res : man_res;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb_q[$];

  ysyx_22041412_mul_ctrl #(
    .XLEN    (64),
    .TIMEOUT (40),
    .CNT_W   (6)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_op_i           (req_op_i),
    .req_src1_i         (req_src1_i),
    .req_src2_i         (req_src2_i),
    .req_rd_i           (req_rd_i),
    .busy_o             (busy_o),
    .wb_valid_o         (wb_valid_o),
    .wb_ready_i         (wb_ready_i),
    .wb_data_o          (wb_data_o),
    .wb_rd_o            (wb_rd_o),
    .err_o              (err_o),
    .mul_req_o          (mul_req_o),
    .mul_multiplicand_o (mul_multiplicand_o),
    .mul_multiplier_o   (mul_multiplier_o),
    .mulw_o             (mulw_o),
    .mul_signed_o       (mul_signed_o),
    .mul_mode_o         (mul_mode_o),
    .mul_flush_o        (mul_flush_o),
    .mul_ready_o        (mul_ready_o),
    .mul_done_i         (mul_done_i),
    .mul_result_i       (mul_result_i)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier driven by the DUT's control outputs. Word results
  // carry junk in the upper half so the controller must sign-extend.
  function automatic logic [63:0] stub_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic w, input logic [1:0] s, input logic m);
    logic [127:0] ea, eb, p;
    if (w) begin
      p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
      return {32'hA5A5A5A5, p[31:0]};
    end
    ea = s[1] ? {{64{a[63]}}, a} : {64'b0, a};
    eb = s[0] ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return m ? p[127:64] : p[63:0];
  endfunction

  always @(negedge clk) begin
    if (stub_en && mul_req_o) begin
      if (stub_cnt + 1 >= stub_lat) begin
        stub_done <= 1'b1;
        stub_res  <= stub_mul(mul_multiplicand_o, mul_multiplier_o, mulw_o, mul_signed_o,
                              mul_mode_o);
        stub_cnt  <= 0;
      end else begin
        stub_done <= 1'b0;
        stub_cnt  <= stub_cnt + 1;
      end
    end else begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; caller ensures the DUT is idle.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_src1_i  = a;
    req_src2_i  = b;
    req_rd_i    = rd;
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_wb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (wb_valid_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [206:0] all;
    rst = 1'b0;
    tick();
    tick();
    all = {mul_req_o, mul_ready_o, mul_flush_o, err_o, wb_valid_o, busy_o, mulw_o,
           mul_mode_o, mul_signed_o, wb_rd_o, wb_data_o, mul_multiplicand_o,
           mul_multiplier_o};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %0h required 0", all);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: ready=%b busy=%b required 1 0", req_ready_o, busy_o);
    end
  endtask

  task automatic test_mul();
    bit   ok;
    exp_t e;
    stub_en  = 1'b1;
    stub_lat = 4;
    sb_q.push_back('{data: 64'hFFFFFFFFFFFFFFF1, rd: 5'd9});
    issue(3'd0, 64'd3, 64'hFFFFFFFFFFFFFFFB, 5'd9);
    checks++;
    if ({mul_req_o, mul_ready_o, mulw_o, mul_signed_o, mul_mode_o} !== 6'b110000) begin
      errors++;
      $display("FAIL mul_ctrl: got %b required 110000",
               {mul_req_o, mul_ready_o, mulw_o, mul_signed_o, mul_mode_o});
    end
    checks++;
    if (mul_multiplicand_o !== 64'd3 || mul_multiplier_o !== 64'hFFFFFFFFFFFFFFFB) begin
      errors++;
      $display("FAIL mul_operands: got %h %h required 3 fffffffffffffffb",
               mul_multiplicand_o, mul_multiplier_o);
    end
    wait_wb(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mul_wb_timeout: got no wb_valid required wb_valid");
    end else begin
      e = sb_q.pop_front();
      if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
        errors++;
        $display("FAIL mul_wb: got %h rd %0d required %h rd %0d", wb_data_o, wb_rd_o,
                 e.data, e.rd);
      end
    end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mul_handshake: valid=%b busy=%b required 0 0", wb_valid_o, busy_o);
    end
  endtask

  task automatic test_mulh_family();
    logic [2:0]  ops  [3] = '{3'd1, 3'd3, 3'd2};
    logic [63:0] exps [3] = '{64'h0, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFF};
    logic [3:0]  ctls [3] = '{4'b0111, 4'b0001, 4'b0101};
    bit          ok;
    exp_t        e;
    stub_en  = 1'b1;
    stub_lat = 5;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{data: exps[i], rd: 5'(10 + i)});
      issue(ops[i], 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'(10 + i));
      checks++;
      if ({mulw_o, mul_signed_o, mul_mode_o} !== ctls[i]) begin
        errors++;
        $display("FAIL mulh_ctrl op%0d: got %b required %b", ops[i],
                 {mulw_o, mul_signed_o, mul_mode_o}, ctls[i]);
      end
      wait_wb(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL mulh_wb_timeout op%0d: got no wb_valid required wb_valid", ops[i]);
      end else begin
        e = sb_q.pop_front();
        if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
          errors++;
          $display("FAIL mulh_wb op%0d: got %h rd %0d required %h rd %0d", ops[i],
                   wb_data_o, wb_rd_o, e.data, e.rd);
        end
      end
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
    end
  endtask

  task automatic test_mulw();
    logic [63:0] as   [2] = '{64'h000000007FFFFFFF, 64'hDEADBEEF00000003};
    logic [63:0] bs   [2] = '{64'h2, 64'h1234567800000004};
    logic [63:0] exps [2] = '{64'hFFFFFFFFFFFFFFFE, 64'h000000000000000C};
    bit          ok;
    exp_t        e;
    stub_en  = 1'b1;
    stub_lat = 3;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{data: exps[i], rd: 5'(20 + i)});
      issue(3'd4, as[i], bs[i], 5'(20 + i));
      checks++;
      if ({mulw_o, mul_signed_o, mul_mode_o} !== 4'b1000) begin
        errors++;
        $display("FAIL mulw_ctrl %0d: got %b required 1000", i,
                 {mulw_o, mul_signed_o, mul_mode_o});
      end
      wait_wb(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL mulw_wb_timeout %0d: got no wb_valid required wb_valid", i);
      end else begin
        e = sb_q.pop_front();
        if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
          errors++;
          $display("FAIL mulw_wb %0d: got %h rd %0d required %h rd %0d", i, wb_data_o,
                   wb_rd_o, e.data, e.rd);
        end
      end
      wb_ready_i = 1'b1;
      tick();
      wb_ready_i = 1'b0;
    end
  endtask

  task automatic test_flush();
    int   wb_seen;
    bit   ok;
    exp_t e;
    stub_en  = 1'b1;
    stub_lat = 20;
    issue(3'd0, 64'd11, 64'd13, 5'd4);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (mul_req_o !== 1'b0 || mul_flush_o !== 1'b1 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_abort: req=%b mflush=%b ready=%b required 0 1 0", mul_req_o,
               mul_flush_o, req_ready_o);
    end
    tick();
    checks++;
    if (mul_flush_o !== 1'b0 || req_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: mflush=%b ready=%b wbv=%b required 0 1 0", mul_flush_o,
               req_ready_o, wb_valid_o);
    end
    wb_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (wb_valid_o) wb_seen++;
      tick();
    end
    checks++;
    if (wb_seen != 0) begin
      errors++;
      $display("FAIL flush_no_wb: got %0d wb cycles required 0", wb_seen);
    end
    stub_lat = 4;
    sb_q.push_back('{data: 64'd42, rd: 5'd3});
    issue(3'd0, 64'd7, 64'd6, 5'd3);
    wait_wb(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL flush_next_timeout: got no wb_valid required wb_valid");
    end else begin
      e = sb_q.pop_front();
      if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
        errors++;
        $display("FAIL flush_next_wb: got %h rd %0d required %h rd %0d", wb_data_o, wb_rd_o,
                 e.data, e.rd);
      end
    end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i = 1'b0;
  endtask

  task automatic test_flush_vs_done();
    stub_en  = 1'b0;
    man_done = 1'b0;
    issue(3'd0, 64'd5, 64'd5, 5'd6);
    tick();
    tick();
    flush    = 1'b1;
    man_done = 1'b1;
    man_res  = 64'd123;
    tick();
    flush = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || mul_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_wins: wbv=%b mflush=%b required 0 1", wb_valid_o, mul_flush_o);
    end
    // Late done while aborting.
    tick();
    man_done = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL late_done: wbv=%b busy=%b ready=%b required 0 0 1", wb_valid_o, busy_o,
               req_ready_o);
    end
    man_done = 1'b1;
    tick();
    man_done = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_done: wbv=%b busy=%b required 0 0", wb_valid_o, busy_o);
    end
    stub_en = 1'b1;
  endtask

  task automatic test_wb_stall();
    bit          ok;
    exp_t        e;
    logic [63:0] held;
    stub_en  = 1'b1;
    stub_lat = 3;
    sb_q.push_back('{data: 64'h200, rd: 5'd17});
    issue(3'd0, 64'h10, 64'h20, 5'd17);
    wait_wb(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_wb_timeout: got no wb_valid required wb_valid");
    end else begin
      e = sb_q.pop_front();
      if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
        errors++;
        $display("FAIL stall_wb: got %h rd %0d required %h rd %0d", wb_data_o, wb_rd_o,
                 e.data, e.rd);
      end
    end
    held        = 64'h200;
    req_valid_i = 1'b1;
    req_op_i    = 3'd0;
    req_src1_i  = 64'd1;
    req_src2_i  = 64'd1;
    req_rd_i    = 5'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (wb_valid_o !== 1'b1 || wb_data_o !== held || busy_o !== 1'b1 ||
          req_ready_o !== 1'b0 || mul_req_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold %0d: v=%b d=%h busy=%b rdy=%b mreq=%b required 1 %h 1 0 0",
                 i, wb_valid_o, wb_data_o, busy_o, req_ready_o, mul_req_o, held);
      end
    end
    wb_ready_i = 1'b1;
    tick();
    wb_ready_i  = 1'b0;
    req_valid_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_accept: wbv=%b busy=%b required 0 0", wb_valid_o, busy_o);
    end
  endtask

  task automatic test_done_flush();
    bit ok;
    stub_en  = 1'b1;
    stub_lat = 3;
    issue(3'd0, 64'd2, 64'd2, 5'd8);
    wait_wb(ok);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (!ok || wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL done_flush: seen=%b wbv=%b busy=%b required 1 0 0", ok, wb_valid_o,
               busy_o);
    end
  endtask

  task automatic test_timeout();
    int n_err = 0;
    int err_at = -1;
    int wb_seen = 0;
    logic abort40 = 1'b0;
    logic rdy41 = 1'b0;
    stub_en  = 1'b0;
    man_done = 1'b0;
    issue(3'd1, 64'd9, 64'd9, 5'd2);
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (err_o) begin
        n_err++;
        err_at = k;
      end
      if (k == 40) abort40 = mul_flush_o & ~mul_req_o;
      if (k == 41) rdy41 = req_ready_o;
      if (wb_valid_o) wb_seen++;
    end
    checks++;
    if (n_err != 1 || err_at != 40) begin
      errors++;
      $display("FAIL timeout_err: got %0d pulses at %0d required 1 at 40", n_err, err_at);
    end
    checks++;
    if (abort40 !== 1'b1 || rdy41 !== 1'b1 || wb_seen != 0) begin
      errors++;
      $display("FAIL timeout_abort: abort=%b rdy=%b wb=%0d required 1 1 0", abort40, rdy41,
               wb_seen);
    end
    stub_en = 1'b1;
  endtask

  task automatic test_illegal();
    exp_t e;
    int   req_seen = 0;
    sb_q.push_back('{data: 64'h0, rd: 5'd21});
    issue(3'd7, 64'd123, 64'd456, 5'd21);
    checks++;
    if (wb_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL illegal_valid: got %b required 1", wb_valid_o);
    end else begin
      e = sb_q.pop_front();
      if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
        errors++;
        $display("FAIL illegal_wb: got %h rd %0d required %h rd %0d", wb_data_o, wb_rd_o,
                 e.data, e.rd);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (mul_req_o) req_seen++;
      tick();
    end
    wb_ready_i = 1'b1;
    if (mul_req_o) req_seen++;
    tick();
    wb_ready_i = 1'b0;
    checks++;
    if (req_seen != 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_no_req: got %0d req cycles busy=%b required 0 0", req_seen,
               busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops  [4] = '{3'd0, 3'd3, 3'd4, 3'd1};
    logic [63:0] as   [4] = '{64'd7, 64'h8000000000000000, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFE};
    logic [63:0] bs   [4] = '{64'd6, 64'd4, 64'hFFFFFFFF, 64'd3};
    logic [63:0] exps [4] = '{64'd42, 64'd2, 64'd1, 64'hFFFFFFFFFFFFFFFF};
    int   idx = 0;
    int   got = 0;
    bit   acc;
    exp_t e;
    stub_en     = 1'b1;
    stub_lat    = 2;
    wb_ready_i  = 1'b1;
    req_valid_i = 1'b1;
    req_op_i    = ops[0];
    req_src1_i  = as[0];
    req_src2_i  = bs[0];
    req_rd_i    = 5'd24;
    for (int c = 0; c < 200 && got < 4; c++) begin
      if (wb_valid_o) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra: got wb %h required none", wb_data_o);
        end else begin
          e = sb_q.pop_front();
          if (wb_data_o !== e.data || wb_rd_o !== e.rd) begin
            errors++;
            $display("FAIL b2b_wb %0d: got %h rd %0d required %h rd %0d", got, wb_data_o,
                     wb_rd_o, e.data, e.rd);
          end
        end
        got++;
      end
      acc = req_valid_i && req_ready_o;
      if (acc) sb_q.push_back('{data: exps[idx], rd: 5'(24 + idx)});
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) begin
          req_op_i   = ops[idx];
          req_src1_i = as[idx];
          req_src2_i = bs[idx];
          req_rd_i   = 5'(24 + idx);
        end else begin
          req_valid_i = 1'b0;
        end
      end
    end
    req_valid_i = 1'b0;
    wb_ready_i  = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d results required 4", got);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh_family();
    test_mulw();
    test_flush();
    test_flush_vs_done();
    test_wb_stall();
    test_done_flush();
    test_timeout();
    test_illegal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish required finish");
    $fatal(1);
  end

endmodule

// File: doc/ysyx_22041412_mul_ctrl.md
Name: ysyx_22041412_mul_ctrl

Overview:
EXU-side initiator for the iterative radix-4 Booth multiplier. It accepts an RV64M multiply op from the execute stage and decodes MUL/MULH/MULHSU/MULHU/MULW into the multiplier's mulw/signed/mode controls. It drives the multiplier's hold-valid request protocol, captures the one-cycle result pulse, sign-extends MULW results and presents a buffered write-back. It also handles pipeline flush and a response watchdog.

Parameters:
XLEN, 64, operand/result width
TIMEOUT, 40, max cycles in REQ before abort
CNT_W, 6, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  pipeline flush; abandon current op
req_valid_i  in  1  op request from EXU
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW, 5-7 illegal
req_src1_i  in  XLEN  rs1, driven as multiplicand
req_src2_i  in  XLEN  rs2, driven as multiplier
req_rd_i  in  5  destination tag
busy_o  out  1  pipeline stall; high whenever state != IDLE
wb_valid_o  out  1  result valid
wb_ready_i  in  1  write-back accepts
wb_data_o  out  XLEN  result
wb_rd_o  out  5  destination tag
err_o  out  1  one-cycle pulse on watchdog timeout
mul_req_o  out  1  to multiplier valid input; held high for the whole computation
mul_multiplicand_o  out  XLEN  latched src1
mul_multiplier_o  out  XLEN  latched src2
mulw_o  out  1  32-bit op
mul_signed_o  out  2  [1] multiplicand signed, [0] multiplier signed
mul_mode_o  out  1  1 selects high half
mul_flush_o  out  1  one-cycle pulse on abort
mul_ready_o  out  1  high in REQ
mul_done_i  in  1  multiplier result-valid pulse
mul_result_i  in  XLEN  multiplier result, valid only while mul_done_i=1

Behaviour:
- Reset (rst=0, async): state IDLE; every output 0; watchdog counter 0.
- States: IDLE, REQ, DONE, ABORT. All outputs are registered except req_ready_o and busy_o.
- req_ready_o = (state==IDLE) & ~flush.
- IDLE, on valid&ready:
  - latch src1, src2, rd and op;
  - drive decoded controls: MUL 00/0, MULH 11/1, MULHSU 10/1, MULHU 00/1, MULW mulw=1 signed=00 mode=0;
  - go to REQ; mul_req_o=1 from the next cycle.
- Illegal op (5-7): no mul_req_o; go straight to DONE with wb_data_o=0.
- REQ:
  - mul_req_o stays high; counter increments each cycle.
  - On mul_done_i: capture result (MULW: sign-extend bit 31 to 64). mul_req_o goes 0 on the next edge; this is mandatory so the multiplier does not restart. Go to DONE.
  - mul_done_i is ignored in all states except REQ.
- DONE: wb_valid_o=1; wb_data_o and wb_rd_o held stable until wb_ready_i. Handshake returns to IDLE. No new accept is possible in the handshake cycle.
- ABORT:
  - Entered from REQ on flush, or when the counter reaches TIMEOUT without mul_done_i.
  - On entry: mul_req_o=0 and mul_flush_o pulses. Timeout also pulses err_o.
  - Lasts exactly one cycle, so the multiplier sees valid low for at least one cycle. Then go to IDLE.
  - A late mul_done_i arriving during ABORT is discarded.
- flush in DONE: wb_valid_o drops next cycle; go to IDLE with no write-back.
- flush in IDLE: no accept that cycle.
- flush and mul_done_i in the same REQ cycle: flush wins; result discarded.
- Latency: accept -> wb_valid_o is 3 + multiplier iterations, at most 36 cycles for 64-bit operands.
- Counter clears on entry to REQ.

Decomposition:
- Shared package/defines header ysyx_22041412_mul_pkg holds:
  - op codes MUL..MULW;
  - controller state encoding;
  - signed-mode constants SS=2'b11, SU=2'b10, UU=2'b00.
- One combinational sub-module, ysyx_22041412_mul_dec: op -> {legal, mulw, signed[1:0], mode}.

Test Plan:
- MUL 3 x 0xFFFFFFFFFFFFFFFB -> controls 00/0; wb_data 0xFFFFFFFFFFFFFFF1, wb_rd echoed.
- src1=src2=0xFFFFFFFFFFFFFFFF: MULH -> 0x0; MULHU -> 0xFFFFFFFFFFFFFFFE; MULHSU -> 0xFFFFFFFFFFFFFFFF.
- MULW 0x7FFFFFFF x 2 -> 0xFFFFFFFFFFFFFFFE. MULW 0xDEADBEEF00000003 x 0x1234567800000004 -> 0x000000000000000C.
- Flush 5 cycles after accept:
  - mul_req_o low and mul_flush_o pulse next cycle;
  - no wb_valid; req_ready_o high 2 cycles after flush;
  - following MUL 7x6 -> 42.
- wb_ready_i low for 10 cycles after result: wb_valid_o and wb_data_o stable, busy_o=1, req_ready_o=0, mul_req_o=0.
- Stub multiplier never answers, TIMEOUT=40:
  - err_o single pulse 40 cycles into REQ; return to IDLE; no wb.
  - op 3'd7 -> wb_data 0 one cycle after accept; mul_req_o never asserted.
